// File: rtl/ws2812b_encoder.sv
// Serialises GRB(W) pixel words onto a single WS2812B data line, with a latch gap after the last pixel of a frame.
// Define WS2812B_ENC_RGBW_EN for 32-bit GRBW pixels (SK6812-RGBW); otherwise pixels are 24-bit GRB.
module ws2812b_encoder #(
   parameter int T0H  = 20,
   parameter int T1H  = 40,
   parameter int TBIT = 62,
   parameter int TRST = 3000
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef WS2812B_ENC_RGBW_EN
   input  logic [31:0] pix_data,
`else
   input  logic [23:0] pix_data,
`endif
   input  logic        pix_valid,
   input  logic        pix_last,
   output logic        pix_ready,
   output logic        dout,
   output logic        busy
);

`ifdef WS2812B_ENC_RGBW_EN
   localparam int W = 32;
`else
   localparam int W = 24;
`endif
   localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = $clog2(W);

   localparam logic [CW-1:0] T0H_END  = CW'(T0H - 1);
   localparam logic [CW-1:0] T1H_END  = CW'(T1H - 1);
   localparam logic [CW-1:0] TBIT_END = CW'(TBIT - 1);
   localparam logic [CW-1:0] TRST_END = CW'(TRST - 1);
   localparam logic [BW-1:0] BIDX_TOP = BW'(W - 1);

   typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, LATCH} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [BW-1:0]   bidx, bidx_nx;
   logic [W-1:0]    shreg, shreg_nx;
   logic            last_q, last_nx;
   logic            ready_en;
   logic            xfer;
   logic            bit_end;
   logic            high_end;

   assign bit_end   = (state == BIT_LOW) && (cnt == TBIT_END);
   assign high_end  = (cnt == (shreg[W-1] ? T1H_END : T0H_END));
   // ready_en keeps pix_ready low until the first clock edge after reset release
   assign pix_ready = ready_en && ((state == IDLE) || (bit_end && (bidx == '0) && !last_q));
   assign xfer      = pix_valid && pix_ready;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      bidx_nx  = bidx;
      shreg_nx = shreg;
      last_nx  = last_q;
      case (state)
         IDLE: ;
         BIT_HIGH: begin
            cnt_nx = cnt + 1'b1;
            if (high_end) state_nx = BIT_LOW;
         end
         BIT_LOW: begin
            if (cnt == TBIT_END) begin
               cnt_nx = '0;
               if (bidx != '0) begin
                  bidx_nx  = bidx - 1'b1;
                  shreg_nx = {shreg[W-2:0], 1'b0};
                  state_nx = BIT_HIGH;
               end else if (last_q) begin
                  state_nx = LATCH;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         LATCH: begin
            if (cnt == TRST_END) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      // A transfer can only happen in IDLE or the last cycle of bit 0, so it overrides either path
      if (xfer) begin
         state_nx = BIT_HIGH;
         shreg_nx = pix_data;
         last_nx  = pix_last;
         bidx_nx  = BIDX_TOP;
         cnt_nx   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bidx     <= '0;
         shreg    <= '0;
         last_q   <= 1'b0;
         dout     <= 1'b0;
         ready_en <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         bidx     <= bidx_nx;
         shreg    <= shreg_nx;
         last_q   <= last_nx;
         dout     <= (state_nx == BIT_HIGH);
         ready_en <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n)
         assert (T0H >= 1 && T0H < T1H && T1H < TBIT)
            else $error("ws2812b_encoder: need 1 <= T0H < T1H < TBIT");
   end

endmodule

// File: tb/tb_ws2812b_encoder.sv
// Scoreboard bench for ws2812b_encoder: accepted pixels are queued, a monitor predicts every dout/busy/pix_ready cycle
// from the pixel word and its acceptance cycle, and decodes the dout pulses back into a word.
module tb_ws2812b_encoder;

   localparam int T0H  = 20;
   localparam int T1H  = 40;
   localparam int TBIT = 62;
   localparam int TRST = 3000;
`ifdef WS2812B_ENC_RGBW_EN
   localparam int W = 32;
`else
   localparam int W = 24;
`endif
   localparam int PIX_CYC = W * TBIT;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] pix_data = '0;
   logic         pix_valid = 1'b0;
   logic         pix_last = 1'b0;
   logic         pix_ready;
   logic         dout;
   logic         busy;

   ws2812b_encoder #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)) dut (
      .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_last(pix_last), .pix_ready(pix_ready), .dout(dout), .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] word;
      logic         last;
      int unsigned  acc;
   } pix_t;

   pix_t        exp_q[$];
   int unsigned armed_cyc = 32'hFFFF_FFFF;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: one prediction per cycle, derived from the bit timing rules of the line protocol
   pix_t         act;
   bit           act_v = 0;
   int unsigned  m_c, m_off, m_i, m_o, hi_cnt;
   logic         m_b, exp_d, exp_b, exp_r;
   logic [W-1:0] dec;

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         check_output("reset_outputs", {29'd0, dout, busy, pix_ready}, 32'd0);
         act_v = 0;
      end else begin
         m_c = cyc;
         if (act_v && m_c >= act.acc + PIX_CYC + (act.last ? TRST : 0)) act_v = 0;
         if (!act_v && exp_q.size() > 0 && exp_q[0].acc <= m_c) begin
            act    = exp_q.pop_front();
            act_v  = 1;
            dec    = '0;
            hi_cnt = 0;
         end
         if (act_v) begin
            exp_b = 1'b1;
            m_off = m_c - act.acc;
            if (m_off < PIX_CYC) begin
               m_i   = m_off / TBIT;
               m_o   = m_off % TBIT;
               m_b   = act.word[W-1-m_i];
               exp_d = (m_o < (m_b ? T1H : T0H));
               exp_r = (m_off == PIX_CYC - 1) && !act.last;
               hi_cnt += dout;
               if (m_o == TBIT - 1) begin
                  dec    = {dec[W-2:0], (hi_cnt == T1H)};
                  hi_cnt = 0;
               end
               if (m_off == PIX_CYC - 1) check_output("pixel_word", 32'(dec), 32'(act.word));
            end else begin
               exp_d = 1'b0;
               exp_r = 1'b0;
            end
         end else begin
            exp_b = 1'b0;
            exp_d = 1'b0;
            exp_r = (m_c >= armed_cyc);
         end
         check_output("dout_busy_ready", {29'd0, dout, busy, pix_ready}, {29'd0, exp_d, exp_b, exp_r});
      end
   end

   // Called at a falling edge; returns at the falling edge just after the accepting clock edge
   task automatic apply_stimulus(input logic [W-1:0] word, input logic last);
      bit done = 0;
      pix_data  = word;
      pix_last  = last;
      pix_valid = 1'b1;
      for (int k = 0; k < PIX_CYC + TRST + 100 && !done; k++) begin
         if (pix_ready) begin
            exp_q.push_back('{word, last, cyc + 1});
            done = 1;
         end
         @(negedge clk);
      end
      check_output("accept_in_time", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset(input int hold);
      #3 rst_n = 1'b0;
      #1 check_output("async_reset", {29'd0, dout, busy, pix_ready}, 32'd0);
      exp_q.delete();
      pix_valid = 1'b0;
      wait_cycles(hold);
      #3 rst_n = 1'b1;
      armed_cyc = cyc + 1;
      @(negedge clk);
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2 rst_n = 1'b0;
      #1 check_output("reset_state", {29'd0, dout, busy, pix_ready}, 32'd0);
      wait_cycles(3);
      #3 rst_n = 1'b1;
      armed_cyc = cyc + 1;
      @(negedge clk);

      $display("[TB] single pixel with latch");
      apply_stimulus(W'(24'h800001), 1'b1);
      pix_valid = 1'b0;
      wait_cycles(PIX_CYC + TRST + 10);

      $display("[TB] back-to-back pixels");
      apply_stimulus(W'(24'hFFFFFF), 1'b0);
      apply_stimulus(W'(24'h000000), 1'b1);
      pix_valid = 1'b0;
      wait_cycles(PIX_CYC + TRST + 10);

      $display("[TB] pixel without last, then idle");
      apply_stimulus(W'($urandom), 1'b0);
      pix_valid = 1'b0;
      wait_cycles(PIX_CYC + 20);
      check_output("idle_after_pixel", {29'd0, dout, busy, pix_ready}, 32'd1);

      $display("[TB] reset in mid-pixel");
      apply_stimulus(W'($urandom), 1'b0);
      pix_valid = 1'b0;
      wait_cycles(10 * TBIT + 7);
      pulse_reset(4);
      apply_stimulus(W'($urandom), 1'b1);
      pix_valid = 1'b0;
      wait_cycles(PIX_CYC + 100);

      $display("[TB] valid pulse during latch");
      pix_data  = W'($urandom);
      pix_last  = 1'b0;
      pix_valid = 1'b1;
      wait_cycles(5);
      pix_valid = 1'b0;
      wait_cycles(TRST + 10);

      $display("[TB] random pixel stream");
      for (int n = 0; n < 6; n++) begin
         apply_stimulus(W'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) != 0) begin
            pix_valid = 1'b0;
            wait_cycles($urandom_range(1, 200));
         end
      end
      pix_valid = 1'b0;
      wait_cycles(PIX_CYC + TRST + 10);

`ifdef WS2812B_ENC_RGBW_EN
      $display("[TB] RGBW pixel");
      apply_stimulus(32'h0000_0001, 1'b1);
      pix_valid = 1'b0;
      wait_cycles(PIX_CYC + TRST + 10);
`endif

      check_output("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
